// File: rtl/ttc_pingpong_buf_ctrl_if.sv
// Writer/CPU handshake bundle for the two-bank telecommand receive buffer controller.
// The master side (writer + CPU) drives requests; the slave side (controller) drives status.
interface ttc_pingpong_buf_ctrl_if #(
    parameter int AW    = 4,
    parameter int CNT_W = 16
);
    logic             WR_REQ;
    logic             WR_DONE;
    logic             WR_ABORT;
    logic             CPU_REL_A;
    logic             CPU_REL_B;
    logic             CLR_OVF;
    logic             WR_GRANT;
    logic             WR_BANK;
    logic [AW-1:0]    WR_BASE;
    logic             BANK_A_READY;
    logic             BANK_B_READY;
    logic             RD_BANK;
    logic             IRQ;
    logic             OVF_FLAG;
    logic [7:0]       OVF_CNT;
    logic [CNT_W-1:0] FRAME_CNT;

    modport master (
        output WR_REQ, WR_DONE, WR_ABORT, CPU_REL_A, CPU_REL_B, CLR_OVF,
        input  WR_GRANT, WR_BANK, WR_BASE, BANK_A_READY, BANK_B_READY,
               RD_BANK, IRQ, OVF_FLAG, OVF_CNT, FRAME_CNT
    );

    modport slave (
        input  WR_REQ, WR_DONE, WR_ABORT, CPU_REL_A, CPU_REL_B, CLR_OVF,
        output WR_GRANT, WR_BANK, WR_BASE, BANK_A_READY, BANK_B_READY,
               RD_BANK, IRQ, OVF_FLAG, OVF_CNT, FRAME_CNT
    );
endinterface

// File: rtl/ttc_pingpong_buf_ctrl.sv
// Ping-pong ownership controller for the A/B telecommand receive buffer: grants a free bank
// per frame, commits good frames to the CPU with an IRQ, and counts frames dropped for lack of space.
module ttc_pingpong_buf_ctrl #(
    parameter int BANK_WORDS = 8,
    parameter int AW         = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    ttc_pingpong_buf_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_READY} bank_st_t;
    typedef enum logic {ST_IDLE, ST_GRANT} fsm_st_t;

    localparam logic [AW-1:0] BASE_B = AW'(BANK_WORDS);

    fsm_st_t          fsm_reg, fsm_next;
    logic             wr_bank_reg;
    logic             next_bank_reg;
    logic             rd_bank_reg, rd_bank_next;
    logic             irq_reg;
    logic             ovf_flag_reg;
    logic [7:0]       ovf_cnt_reg;
    logic [CNT_W-1:0] frame_cnt_reg;

    logic [1:0] rel_req;
    logic [1:0] free_rel;
    logic [1:0] ready_reg;
    logic [1:0] ready_next;
    logic       alloc, commit, abort, drop;
    logic       sel_bank;

    assign rel_req = {bus.CPU_REL_B, bus.CPU_REL_A};

    // Per-bank state; releases are folded in before allocation sees the bank.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            bank_st_t bank_reg, bank_rel, bank_next;

            assign bank_rel = (rel_req[gi] && bank_reg == BANK_READY) ? BANK_FREE : bank_reg;

            always_comb begin
                bank_next = bank_rel;
                if (alloc && sel_bank == 1'(gi))
                    bank_next = BANK_FILL;
                else if (abort && wr_bank_reg == 1'(gi))
                    bank_next = BANK_FREE;
                else if (commit && wr_bank_reg == 1'(gi))
                    bank_next = BANK_READY;
            end

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) bank_reg <= BANK_FREE;
                else      bank_reg <= bank_next;
            end

            assign free_rel[gi]   = (bank_rel == BANK_FREE);
            assign ready_reg[gi]  = (bank_reg == BANK_READY);
            assign ready_next[gi] = (bank_next == BANK_READY);
        end
    endgenerate

    always_comb begin
        fsm_next = fsm_reg;
        alloc    = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        drop     = 1'b0;
        sel_bank = next_bank_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (bus.WR_REQ) begin
                    if (&free_rel)        sel_bank = next_bank_reg;
                    else if (free_rel[0]) sel_bank = 1'b0;
                    else                  sel_bank = 1'b1;
                    if (|free_rel) begin
                        alloc    = 1'b1;
                        fsm_next = ST_GRANT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                // Abort takes priority so a frame flagged bad is never handed to the CPU.
                if (bus.WR_ABORT) begin
                    abort    = 1'b1;
                    fsm_next = ST_IDLE;
                end else if (bus.WR_DONE) begin
                    commit   = 1'b1;
                    fsm_next = ST_IDLE;
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    // With both banks READY the read pointer keeps naming the older commit.
    always_comb begin
        rd_bank_next = rd_bank_reg;
        case (ready_next)
            2'b01:   rd_bank_next = 1'b0;
            2'b10:   rd_bank_next = 1'b1;
            default: rd_bank_next = rd_bank_reg;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fsm_reg       <= ST_IDLE;
            wr_bank_reg   <= 1'b0;
            next_bank_reg <= 1'b0;
            rd_bank_reg   <= 1'b0;
            irq_reg       <= 1'b0;
            ovf_flag_reg  <= 1'b0;
            ovf_cnt_reg   <= 8'd0;
            frame_cnt_reg <= '0;
        end else begin
            fsm_reg     <= fsm_next;
            rd_bank_reg <= rd_bank_next;
            irq_reg     <= commit;
            if (alloc)
                wr_bank_reg <= sel_bank;
            if (commit) begin
                next_bank_reg <= ~wr_bank_reg;
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (bus.CLR_OVF) begin
                ovf_flag_reg <= 1'b0;
                ovf_cnt_reg  <= 8'd0;
            end else if (drop) begin
                ovf_flag_reg <= 1'b1;
                if (ovf_cnt_reg != 8'hFF)
                    ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.WR_GRANT     = (fsm_reg == ST_GRANT);
    assign bus.WR_BANK      = wr_bank_reg;
    assign bus.WR_BASE      = wr_bank_reg ? BASE_B : '0;
    assign bus.BANK_A_READY = ready_reg[0];
    assign bus.BANK_B_READY = ready_reg[1];
    assign bus.RD_BANK      = rd_bank_reg;
    assign bus.IRQ          = irq_reg;
    assign bus.OVF_FLAG     = ovf_flag_reg;
    assign bus.OVF_CNT      = ovf_cnt_reg;
    assign bus.FRAME_CNT    = frame_cnt_reg;
endmodule
